// File: rtl/reg_writeback_unit.sv
// Write-back stage: arbitrates ALU and load results onto the register bank write port
// and tracks pending writes for decode. Optional forwarding outputs under WB_BYPASS_EN.
module reg_writeback_unit #(
    parameter int unsigned DATA_W       = 64,
    parameter int unsigned ADDR_W       = 5,
    parameter int unsigned STARVE_LIMIT = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [ADDR_W-1:0] alu_rd,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] ld_rd,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              iss_valid,
    input  logic [ADDR_W-1:0] iss_rd,
    input  logic [ADDR_W-1:0] q_rs1,
    input  logic [ADDR_W-1:0] q_rs2,
    output logic              busy1,
    output logic              busy2,
    output logic              sb_conflict,
    output logic              rf_write,
    output logic [ADDR_W-1:0] rf_addr,
    output logic [DATA_W-1:0] rf_data
`ifdef WB_BYPASS_EN
    ,
    output logic              fwd1_hit,
    output logic              fwd2_hit,
    output logic [DATA_W-1:0] fwd1_data,
    output logic [DATA_W-1:0] fwd2_data
`endif
);

    localparam int unsigned NREG  = 1 << ADDR_W;
    localparam int unsigned CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [ADDR_W-1:0] XZR = ADDR_W'(NREG - 1);

    logic              alu_full, ld_full;
    logic [ADDR_W-1:0] alu_rd_q, ld_rd_q;
    logic [DATA_W-1:0] alu_data_q, ld_data_q;
    logic [CNT_W-1:0]  starve;
    logic [NREG-1:0]   pending;

    logic              starved_c, alu_gnt_c, ld_gnt_c, gnt_c;
    logic [ADDR_W-1:0] gnt_rd_c;
    logic [DATA_W-1:0] gnt_data_c;
    logic              iss_set_c, conflict_c;
    logic [CNT_W-1:0]  starve_nxt_c;
    logic [NREG-1:0]   pending_nxt_c;

    // Load has priority; a starved ALU entry overrides it once.
    assign starved_c = (starve == CNT_W'(STARVE_LIMIT));
    assign alu_gnt_c = alu_full & (~ld_full | starved_c);
    assign ld_gnt_c  = ld_full & ~alu_gnt_c;
    assign gnt_c     = alu_gnt_c | ld_gnt_c;
    assign alu_ready = ~alu_full | alu_gnt_c;
    assign ld_ready  = ~ld_full | ld_gnt_c;
    assign gnt_rd_c   = alu_gnt_c ? alu_rd_q : ld_rd_q;
    assign gnt_data_c = alu_gnt_c ? alu_data_q : ld_data_q;
    assign iss_set_c  = iss_valid & (iss_rd != XZR);
    assign conflict_c = iss_set_c & pending[iss_rd] & ~(rf_write & (rf_addr == iss_rd));

    always_comb begin
        starve_nxt_c = '0;
        if (alu_full & ~alu_gnt_c)
            starve_nxt_c = starved_c ? starve : starve + CNT_W'(1);
    end

    // Clear on bank capture, then set on issue so a same-edge set wins.
    always_comb begin
        pending_nxt_c = pending;
        if (rf_write)
            pending_nxt_c[rf_addr] = 1'b0;
        if (iss_set_c)
            pending_nxt_c[iss_rd] = 1'b1;
        pending_nxt_c[NREG-1] = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            alu_full    <= 1'b0;
            ld_full     <= 1'b0;
            alu_rd_q    <= '0;
            ld_rd_q     <= '0;
            alu_data_q  <= '0;
            ld_data_q   <= '0;
            starve      <= '0;
            pending     <= '0;
            sb_conflict <= 1'b0;
            rf_write    <= 1'b0;
            rf_addr     <= '0;
            rf_data     <= '0;
        end else begin
            if (alu_valid & alu_ready) begin
                alu_full   <= 1'b1;
                alu_rd_q   <= alu_rd;
                alu_data_q <= alu_data;
            end else if (alu_gnt_c) begin
                alu_full <= 1'b0;
            end
            if (ld_valid & ld_ready) begin
                ld_full   <= 1'b1;
                ld_rd_q   <= ld_rd;
                ld_data_q <= ld_data;
            end else if (ld_gnt_c) begin
                ld_full <= 1'b0;
            end
            starve      <= starve_nxt_c;
            pending     <= pending_nxt_c;
            sb_conflict <= conflict_c;
            rf_write    <= gnt_c & (gnt_rd_c != XZR);
            if (gnt_c) begin
                rf_addr <= gnt_rd_c;
                rf_data <= gnt_data_c;
            end
        end
    end

`ifdef WB_BYPASS_EN
    assign fwd1_hit  = rf_write & (rf_addr == q_rs1) & (q_rs1 != XZR);
    assign fwd2_hit  = rf_write & (rf_addr == q_rs2) & (q_rs2 != XZR);
    assign fwd1_data = rf_data;
    assign fwd2_data = rf_data;
    assign busy1     = pending[q_rs1] & ~fwd1_hit;
    assign busy2     = pending[q_rs2] & ~fwd2_hit;
`else
    assign busy1 = pending[q_rs1];
    assign busy2 = pending[q_rs2];
`endif

endmodule

// File: tb/tb_reg_writeback_unit.sv
// Directed bench for reg_writeback_unit with a behavioural register bank.
module tb_reg_writeback_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        alu_valid, alu_ready, ld_valid, ld_ready, iss_valid;
    logic [4:0]  alu_rd, ld_rd, iss_rd, q_rs1, q_rs2, rf_addr;
    logic [63:0] alu_data, ld_data, rf_data;
    logic        busy1, busy2, sb_conflict, rf_write;
`ifdef WB_BYPASS_EN
    logic        fwd1_hit, fwd2_hit;
    logic [63:0] fwd1_data, fwd2_data;
`endif
    logic [63:0] regs [32];
    int          checks = 0;
    int          errors = 0;

    reg_writeback_unit dut (
        .clock(clock), .reset(reset),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .q_rs1(q_rs1), .q_rs2(q_rs2),
        .busy1(busy1), .busy2(busy2), .sb_conflict(sb_conflict),
        .rf_write(rf_write), .rf_addr(rf_addr), .rf_data(rf_data)
`ifdef WB_BYPASS_EN
        , .fwd1_hit(fwd1_hit), .fwd2_hit(fwd2_hit), .fwd1_data(fwd1_data), .fwd2_data(fwd2_data)
`endif
    );

    always #5 clock = ~clock;

    // Register bank stand-in capturing the write port.
    always @(posedge clock)
        if (rf_write) regs[rf_addr] <= rf_data;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic [4:0] exp_seq [8];
        exp_seq = '{5'd2, 5'd2, 5'd2, 5'd1, 5'd2, 5'd2, 5'd2, 5'd1};
        for (int i = 0; i < 32; i++) regs[i] = '0;
        reset = 1'b1;
        alu_valid = 1'b0; ld_valid = 1'b0; iss_valid = 1'b0;
        alu_rd = '0; ld_rd = '0; iss_rd = '0; q_rs1 = '0; q_rs2 = '0;
        alu_data = '0; ld_data = '0;
        step(); step();
        reset = 1'b0;
        #1;
        check("rst_rf_write", 64'(rf_write), 64'd0);
        check("rst_rf_addr", 64'(rf_addr), 64'd0);
        check("rst_rf_data", rf_data, 64'd0);
        check("rst_conflict", 64'(sb_conflict), 64'd0);
        check("rst_alu_ready", 64'(alu_ready), 64'd1);
        check("rst_ld_ready", 64'(ld_ready), 64'd1);
        check("rst_busy1", 64'(busy1), 64'd0);

        // ALU write to r5
        step();
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 64'h1234;
        step();
        alu_valid = 1'b0;
        #1;
        check("alu_no_early_write", 64'(rf_write), 64'd0);
        step();
        check("alu_write", 64'(rf_write), 64'd1);
        check("alu_addr", 64'(rf_addr), 64'd5);
        check("alu_data", rf_data, 64'h1234);
        step();
        check("bank_r5", regs[5], 64'h1234);
        check("alu_write_drop", 64'(rf_write), 64'd0);

        // Pending r7 cleared by a load commit
        iss_valid = 1'b1; iss_rd = 5'd7;
        step();
        iss_valid = 1'b0; q_rs1 = 5'd7;
        #1;
        check("busy1_set", 64'(busy1), 64'd1);
        ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 64'hDEAD;
        step();
        ld_valid = 1'b0;
        step();
        check("ld_write", 64'(rf_write), 64'd1);
        check("ld_addr", 64'(rf_addr), 64'd7);
`ifndef WB_BYPASS_EN
        check("busy1_during_write", 64'(busy1), 64'd1);
`endif
        step();
        check("busy1_cleared", 64'(busy1), 64'd0);
        check("bank_r7", regs[7], 64'hDEAD);

        // Contention: load wins three times, then the ALU once
        alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 64'hA;
        ld_valid = 1'b1; ld_rd = 5'd2; ld_data = 64'hB;
        step();
        for (int i = 0; i < 8; i++) begin
            step();
            check($sformatf("arb_write_%0d", i), 64'(rf_write), 64'd1);
            check($sformatf("arb_addr_%0d", i), 64'(rf_addr), 64'(exp_seq[i]));
        end
        alu_valid = 1'b0; ld_valid = 1'b0;
        step(); step(); step(); step();
        check("arb_drained", 64'(rf_write), 64'd0);

        // XZR writes and issues are dropped
        alu_valid = 1'b1; alu_rd = 5'd31; alu_data = 64'hFFFF;
        iss_valid = 1'b1; iss_rd = 5'd31; q_rs1 = 5'd31;
        #1;
        check("xzr_alu_ready", 64'(alu_ready), 64'd1);
        step();
        alu_valid = 1'b0; iss_valid = 1'b0;
        #1;
        check("xzr_busy1", 64'(busy1), 64'd0);
        step();
        check("xzr_no_write", 64'(rf_write), 64'd0);
        check("xzr_no_conflict", 64'(sb_conflict), 64'd0);

        // Double issue to r3 pulses sb_conflict
        iss_valid = 1'b1; iss_rd = 5'd3;
        step();
        check("first_issue_no_conflict", 64'(sb_conflict), 64'd0);
        step();
        iss_valid = 1'b0; q_rs1 = 5'd3;
        #1;
        check("conflict_pulse", 64'(sb_conflict), 64'd1);
        check("r3_busy", 64'(busy1), 64'd1);
        step();
        check("conflict_one_cycle", 64'(sb_conflict), 64'd0);

        // Same-edge issue and commit of r4: set wins, no conflict
        iss_valid = 1'b1; iss_rd = 5'd4;
        step();
        iss_valid = 1'b0;
        ld_valid = 1'b1; ld_rd = 5'd4; ld_data = 64'h44;
        step();
        ld_valid = 1'b0;
        step();
        check("r4_write", 64'(rf_write), 64'd1);
        iss_valid = 1'b1; iss_rd = 5'd4;
        step();
        iss_valid = 1'b0; q_rs2 = 5'd4;
        #1;
        check("r4_set_wins", 64'(busy2), 64'd1);
        check("r4_no_conflict", 64'(sb_conflict), 64'd0);

        // Reset with both buffers full
        alu_valid = 1'b1; alu_rd = 5'd10; alu_data = 64'h10;
        ld_valid = 1'b1; ld_rd = 5'd11; ld_data = 64'h11;
        step();
        alu_valid = 1'b0; ld_valid = 1'b0; reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        check("prst_alu_ready", 64'(alu_ready), 64'd1);
        check("prst_ld_ready", 64'(ld_ready), 64'd1);
        check("prst_busy1", 64'(busy1), 64'd0);
        check("prst_busy2", 64'(busy2), 64'd0);
        check("prst_no_write0", 64'(rf_write), 64'd0);
        step();
        check("prst_no_write1", 64'(rf_write), 64'd0);
        step();
        check("prst_no_write2", 64'(rf_write), 64'd0);

`ifdef WB_BYPASS_EN
        iss_valid = 1'b1; iss_rd = 5'd9;
        step();
        iss_valid = 1'b0;
        ld_valid = 1'b1; ld_rd = 5'd9; ld_data = 64'h99; q_rs2 = 5'd9;
        step();
        ld_valid = 1'b0;
        step();
        check("fwd2_hit", 64'(fwd2_hit), 64'd1);
        check("fwd2_data", fwd2_data, 64'h99);
        check("fwd2_busy2", 64'(busy2), 64'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
